fan_ctrl_multi: RTL

//  N-channel fan controller: one IIR/PID (biquad) datapath time-multiplexed over CHANNELS

---
 rtl/fanctrl_pkg.sv | 40 ++++
 rtl/fanctrl_pwm.sv | 49 ++++
 rtl/fan_ctrl_multi.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fanctrl_pkg.sv
// rtl/fanctrl_pkg.sv - shared FSM states, datapath width helpers and clamp/saturate functions for fan_ctrl_multi
package fanctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_t;

    localparam int MAC_STEPS = 5;

    // Signed coefficient times signed (ADC+1)-bit error/history sample.
    function automatic int prod_width(input int reg_bw, input int adc_bw);
        return reg_bw + adc_bw + 1;
    endfunction

    // Three guard bits above the product cover the five-term sum.
    function automatic int acc_width(input int reg_bw, input int adc_bw);
        return reg_bw + adc_bw + 4;
    endfunction

    function automatic logic signed [63:0] clamp(input logic signed [63:0] v,
                                                 input logic signed [63:0] lo,
                                                 input logic signed [63:0] hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int bits);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< bits) - 64'sd1;
        lo = -(64'sd1 <<< bits);
        return clamp(v, lo, hi);
    endfunction

endpackage

// File: rtl/fanctrl_pwm.sv
// rtl/fanctrl_pwm.sv - per-channel PWM generator with minimum-duty floor and wrap-synchronous duty reload
module fanctrl_pwm #(
    parameter int ADC_BITWIDTH    = 8,
    parameter int PERIOD_BITWIDTH = 9
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        clk_en_i,
    input  logic signed [ADC_BITWIDTH:0] pid_i,
    input  logic [PERIOD_BITWIDTH-1:0]  period_i,
    input  logic [ADC_BITWIDTH-1:0]     min_i,
    output logic                        pin_o
);
    localparam int DW = (PERIOD_BITWIDTH > ADC_BITWIDTH) ? PERIOD_BITWIDTH : ADC_BITWIDTH;

    logic [PERIOD_BITWIDTH-1:0] cnt;
    logic [DW-1:0]              duty_req;
    logic [DW-1:0]              duty_active;

    always_comb begin
        duty_req = '0;
        if (pid_i > 0) begin
            duty_req = DW'(pid_i[ADC_BITWIDTH-1:0]);
            if (DW'(min_i) > duty_req) duty_req = DW'(min_i);
            if (duty_req > DW'(period_i)) duty_req = DW'(period_i);
        end
    end

    // Duty is only taken over at the period boundary so a pulse is never cut short or stretched.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt         <= '0;
            duty_active <= '0;
        end else if (period_i == '0) begin
            cnt         <= '0;
            duty_active <= duty_req;
        end else if (clk_en_i) begin
            if (cnt >= period_i - 1'b1) begin
                cnt         <= '0;
                duty_active <= duty_req;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign pin_o = (period_i != '0) && (DW'(cnt) < duty_active);

endmodule

// File: rtl/fan_ctrl_multi.sv
// rtl/fan_ctrl_multi.sv - N-channel biquad fan controller on one shared multiplier; FANCTRL_SLEW_EN adds output slew limiting
module fan_ctrl_multi
    import fanctrl_pkg::*;
#(
    parameter int CHANNELS        = 2,
    parameter int ADC_BITWIDTH    = 8,
    parameter int REG_BITWIDTH    = 35,
    parameter int FRAC_BITWIDTH   = 30,
    parameter int PERIOD_BITWIDTH = 9,
    parameter int SLEW_STEP       = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rstn_i,
    input  logic                                 clk_en_PWM_i,
    input  logic                                 dataValid_STRB_i,
    input  logic [CHANNELS*ADC_BITWIDTH-1:0]     ADC_value_i,
    input  logic [CHANNELS*ADC_BITWIDTH-1:0]     SET_value_i,
    input  logic [REG_BITWIDTH-1:0]              a0_i,
    input  logic [REG_BITWIDTH-1:0]              a1_i,
    input  logic [REG_BITWIDTH-1:0]              b0_i,
    input  logic [REG_BITWIDTH-1:0]              b1_i,
    input  logic [REG_BITWIDTH-1:0]              b2_i,
    input  logic [PERIOD_BITWIDTH-1:0]           periodCounterValue_i,
    input  logic [ADC_BITWIDTH-1:0]              minCounterValue_i,
    output logic [CHANNELS-1:0]                  PWM_pin_o,
    output logic [CHANNELS*(ADC_BITWIDTH+1)-1:0] PID_Val_o,
    output logic                                 busy_o,
    output logic                                 done_STRB_o,
    output logic                                 overrun_STRB_o
);
    localparam int EW = ADC_BITWIDTH + 1;
    localparam int PW = prod_width(REG_BITWIDTH, ADC_BITWIDTH);
    localparam int AW = acc_width(REG_BITWIDTH, ADC_BITWIDTH);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

    state_t                           state, state_nxt;
    logic [CW-1:0]                    ch;
    logic [2:0]                       step;
    logic [CHANNELS*ADC_BITWIDTH-1:0] adc_q, set_q;
    logic signed [REG_BITWIDTH-1:0]   coef_q [MAC_STEPS];
    logic signed [EW-1:0]             e_cur;
    logic signed [AW-1:0]             acc;
    logic signed [EW-1:0]             e1 [CHANNELS];
    logic signed [EW-1:0]             e2 [CHANNELS];
    logic signed [EW-1:0]             y1 [CHANNELS];
    logic signed [EW-1:0]             y2 [CHANNELS];
    logic signed [EW-1:0]             pid_q [CHANNELS];
    logic                             overrun_q;

    logic signed [REG_BITWIDTH-1:0]   mul_coef;
    logic signed [EW-1:0]             mul_data, e_new, y_sat, y_out;
    logic signed [PW-1:0]             prod;
    logic signed [AW-1:0]             y_shift;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (dataValid_STRB_i) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_MAC;
            S_MAC:   if (step == 3'(MAC_STEPS - 1)) state_nxt = S_WRITE;
            S_WRITE: state_nxt = (ch == LAST_CH) ? S_DONE : S_LOAD;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Term order: b2*e, b1*e1, b0*e2, then the two feedback terms which are subtracted.
    always_comb begin
        mul_coef = coef_q[0];
        mul_data = e_cur;
        case (step)
            3'd1:    begin mul_coef = coef_q[1]; mul_data = e1[ch]; end
            3'd2:    begin mul_coef = coef_q[2]; mul_data = e2[ch]; end
            3'd3:    begin mul_coef = coef_q[3]; mul_data = y1[ch]; end
            3'd4:    begin mul_coef = coef_q[4]; mul_data = y2[ch]; end
            default: ;
        endcase
    end

    assign prod    = PW'(mul_coef) * PW'(mul_data);
    assign e_new   = $signed({1'b0, set_q[ch*ADC_BITWIDTH +: ADC_BITWIDTH]})
                   - $signed({1'b0, adc_q[ch*ADC_BITWIDTH +: ADC_BITWIDTH]});
    assign y_shift = acc >>> FRAC_BITWIDTH;
    assign y_sat   = EW'(saturate(64'(y_shift), ADC_BITWIDTH));

`ifdef FANCTRL_SLEW_EN
    assign y_out = EW'(clamp(64'(y_sat), 64'(pid_q[ch]) - 64'(SLEW_STEP), 64'(pid_q[ch]) + 64'(SLEW_STEP)));
`else
    logic [31:0] unused_slew_step;
    assign unused_slew_step = 32'(SLEW_STEP);
    assign y_out = y_sat;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ch        <= '0;
            step      <= '0;
            adc_q     <= '0;
            set_q     <= '0;
            e_cur     <= '0;
            acc       <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < MAC_STEPS; i++) coef_q[i] <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                e1[i]    <= '0;
                e2[i]    <= '0;
                y1[i]    <= '0;
                y2[i]    <= '0;
                pid_q[i] <= '0;
            end
        end else begin
            overrun_q <= dataValid_STRB_i && (state != S_IDLE);
            case (state)
                S_IDLE: if (dataValid_STRB_i) begin
                    adc_q     <= ADC_value_i;
                    set_q     <= SET_value_i;
                    coef_q[0] <= b2_i;
                    coef_q[1] <= b1_i;
                    coef_q[2] <= b0_i;
                    coef_q[3] <= a1_i;
                    coef_q[4] <= a0_i;
                    ch        <= '0;
                end
                S_LOAD: begin
                    e_cur <= e_new;
                    acc   <= '0;
                    step  <= '0;
                end
                S_MAC: begin
                    acc  <= (step < 3'd3) ? acc + AW'(prod) : acc - AW'(prod);
                    step <= step + 3'd1;
                end
                S_WRITE: begin
                    pid_q[ch] <= y_out;
                    e2[ch]    <= e1[ch];
                    e1[ch]    <= e_cur;
                    y2[ch]    <= y1[ch];
                    y1[ch]    <= y_out;
                    if (ch != LAST_CH) ch <= ch + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy_o         = (state != S_IDLE);
    assign done_STRB_o    = (state == S_DONE);
    assign overrun_STRB_o = overrun_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign PID_Val_o[i*EW +: EW] = pid_q[i];

        fanctrl_pwm #(
            .ADC_BITWIDTH   (ADC_BITWIDTH),
            .PERIOD_BITWIDTH(PERIOD_BITWIDTH)
        ) u_pwm (
            .clk_i   (clk_i),
            .rstn_i  (rstn_i),
            .clk_en_i(clk_en_PWM_i),
            .pid_i   (pid_q[i]),
            .period_i(periodCounterValue_i),
            .min_i   (minCounterValue_i),
            .pin_o   (PWM_pin_o[i])
        );
    end

endmodule
